// File: rtl/exec_sequencer.sv
// Four-cycle issue/writeback sequencer (IDLE->READ->EXEC->WB) with PSR flag tracking.
// Optional immediate-form instructions are enabled by defining EXEC_IMM_EN.
module exec_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_instr_valid,
    input  logic [WIDTH-1:0] i_instr,
    output logic             o_instr_ready,
    output logic [AW-1:0]    o_ra1,
    output logic [AW-1:0]    o_ra2,
    input  logic [WIDTH-1:0] i_rd1,
    input  logic [WIDTH-1:0] i_rd2,
    output logic [3:0]       o_aluop,
    output logic [3:0]       o_opext,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [AW-1:0]    o_wa,
    output logic [WIDTH-1:0] o_wd,
    output logic             o_regwrite,
    output logic [4:0]       o_psr,
    output logic             o_done,
    output logic             o_illegal
);
    localparam logic [3:0] OpAnd = 4'h1;
    localparam logic [3:0] OpOr  = 4'h2;
    localparam logic [3:0] OpXor = 4'h3;
    localparam logic [3:0] OpAdd = 4'h5;
    localparam logic [3:0] OpSub = 4'h9;
    localparam logic [3:0] OpCmp = 4'hB;
    localparam logic [3:0] OpMov = 4'hD;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_instr, r_op_a, r_op_b, r_res;
    logic [4:0]       r_flags, r_psr, w_flags;

    logic [3:0]       w_opcode, w_rdest, w_opext, w_rsrc, w_op;
    logic             w_legal, w_is_imm;
    logic [WIDTH-1:0] w_op_a_next, w_a, w_b;
    logic [WIDTH:0]   w_sum, w_diff;

    assign w_opcode = r_instr[15:12];
    assign w_rdest  = r_instr[11:8];
    assign w_opext  = r_instr[7:4];
    assign w_rsrc   = r_instr[3:0];

`ifdef EXEC_IMM_EN
    logic [WIDTH-1:0] w_imm_ext;
    // Logical immediates zero-extend; arithmetic immediates sign-extend.
    assign w_imm_ext = (w_op == OpAnd || w_op == OpOr || w_op == OpXor) ?
                       {{(WIDTH-8){1'b0}}, r_instr[7:0]} :
                       {{(WIDTH-8){r_instr[7]}}, r_instr[7:0]};
`endif

    always_comb begin
        w_op     = w_opext;
        w_legal  = 1'b0;
        w_is_imm = 1'b0;
        if (w_opcode == 4'h0) begin
            case (w_opext)
                OpAnd, OpOr, OpXor, OpAdd, OpSub, OpCmp, OpMov: w_legal = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end
`ifdef EXEC_IMM_EN
        else begin
            w_op     = w_opcode;
            w_is_imm = 1'b1;
            case (w_opcode)
                OpAnd, OpOr, OpXor, OpAdd, OpSub, OpCmp: w_legal = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end
`endif
    end

`ifdef EXEC_IMM_EN
    assign w_op_a_next = w_is_imm ? w_imm_ext : i_rd1;
`else
    assign w_op_a_next = i_rd1;
`endif

    // a = Rdest operand, b = Rsrc operand
    assign w_a    = r_op_b;
    assign w_b    = r_op_a;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_flags = r_psr;
        case (w_op)
            OpAdd: begin
                w_flags[4] = w_sum[WIDTH];
                w_flags[2] = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
                w_flags[1] = (w_sum[WIDTH-1:0] == '0);
                w_flags[0] = w_sum[WIDTH-1];
            end
            OpSub, OpCmp: begin
                w_flags[4] = w_diff[WIDTH];
                w_flags[3] = w_diff[WIDTH];
                w_flags[2] = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
                w_flags[1] = (w_diff[WIDTH-1:0] == '0);
                w_flags[0] = $signed(w_a) < $signed(w_b);
            end
            default: begin
                w_flags[1] = (i_alu_result == '0);
                w_flags[0] = i_alu_result[WIDTH-1];
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_instr_valid) w_state_next = StRead;
            StRead:  w_state_next = StExec;
            StExec:  w_state_next = StWb;
            StWb:    w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_psr   <= '0;
        end else begin
            case (r_state)
                StIdle: if (i_instr_valid) r_instr <= i_instr;
                StRead: begin
                    r_op_a <= w_op_a_next;
                    r_op_b <= i_rd2;
                end
                StExec: begin
                    r_res   <= i_alu_result;
                    r_flags <= w_flags;
                end
                StWb:    if (w_legal) r_psr <= r_flags;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_instr_ready = 1'b0;
        o_ra1         = '0;
        o_ra2         = '0;
        o_aluop       = '0;
        o_opext       = '0;
        o_wa          = '0;
        o_wd          = '0;
        o_regwrite    = 1'b0;
        o_done        = 1'b0;
        o_illegal     = 1'b0;
        case (r_state)
            StIdle: o_instr_ready = 1'b1;
            StRead, StExec: begin
                o_ra1   = w_is_imm ? '0 : AW'(w_rsrc);
                o_ra2   = AW'(w_rdest);
                o_aluop = w_opcode;
                o_opext = w_is_imm ? 4'h0 : w_opext;
            end
            StWb: begin
                o_wa       = AW'(w_rdest);
                o_wd       = r_res;
                o_regwrite = w_legal && (w_op != OpCmp);
                o_done     = w_legal;
                o_illegal  = !w_legal;
            end
            default: ;
        endcase
        if (i_reset) begin
            o_instr_ready = 1'b1;
            o_ra1         = '0;
            o_ra2         = '0;
            o_aluop       = '0;
            o_opext       = '0;
            o_wa          = '0;
            o_wd          = '0;
            o_regwrite    = 1'b0;
            o_done        = 1'b0;
            o_illegal     = 1'b0;
        end
    end

    assign o_psr = i_reset ? 5'b0 : r_psr;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a small regfile and ALU model around the DUT.
module tb_exec_sequencer;
    logic        clk = 1'b0;
    logic        reset, instr_valid, instr_ready;
    logic [15:0] instr, rd1, rd2, alu_result, wd;
    logic [3:0]  ra1, ra2, aluop, opext, wa;
    logic        regwrite, done, illegal;
    logic [4:0]  psr;

    logic [15:0] regs [16];
    logic [15:0] cur_imm;
    logic [15:0] src;
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_instr_valid(instr_valid),
        .i_instr      (instr),
        .o_instr_ready(instr_ready),
        .o_ra1        (ra1),
        .o_ra2        (ra2),
        .i_rd1        (rd1),
        .i_rd2        (rd2),
        .o_aluop      (aluop),
        .o_opext      (opext),
        .i_alu_result (alu_result),
        .o_wa         (wa),
        .o_wd         (wd),
        .o_regwrite   (regwrite),
        .o_psr        (psr),
        .o_done       (done),
        .o_illegal    (illegal)
    );

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    always @(posedge clk) if (regwrite) regs[wa] <= wd;

    always_comb begin
        src        = (aluop != 4'h0) ? cur_imm : rd1;
        alu_result = 16'h0;
        case ((aluop != 4'h0) ? aluop : opext)
            4'h1:       alu_result = rd2 & src;
            4'h2:       alu_result = rd2 | src;
            4'h3:       alu_result = rd2 ^ src;
            4'h5:       alu_result = rd2 + src;
            4'h9, 4'hB: alu_result = rd2 - src;
            4'hD:       alu_result = src;
            default:    alu_result = 16'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and check each phase; psr checked once back in IDLE.
    task automatic run(input string tag, input logic [15:0] w, input logic exp_we,
                       input logic [15:0] exp_wd, input logic exp_done, input logic [4:0] exp_psr);
        step();
        instr_valid = 1'b1;
        instr       = w;
        step();
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        chk({tag, ".ready_read"}, {31'b0, instr_ready}, 32'd0);
        if (w[15:12] == 4'h0) begin
            chk({tag, ".ra1"}, {28'b0, ra1}, {28'b0, w[3:0]});
            chk({tag, ".ra2"}, {28'b0, ra2}, {28'b0, w[11:8]});
            chk({tag, ".opext"}, {28'b0, opext}, {28'b0, w[7:4]});
        end
        step();
        chk({tag, ".we_exec"}, {31'b0, regwrite}, 32'd0);
        step();
        chk({tag, ".regwrite"}, {31'b0, regwrite}, {31'b0, exp_we});
        chk({tag, ".done"}, {31'b0, done}, {31'b0, exp_done});
        chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, !exp_done});
        if (exp_we) begin
            chk({tag, ".wa"}, {28'b0, wa}, {28'b0, w[11:8]});
            chk({tag, ".wd"}, {16'b0, wd}, {16'b0, exp_wd});
        end
        step();
        chk({tag, ".psr"}, {27'b0, psr}, {27'b0, exp_psr});
        chk({tag, ".ready_idle"}, {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        cur_imm     = 16'h0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst.ready", {31'b0, instr_ready}, 32'd1);
            chk("rst.regwrite", {31'b0, regwrite}, 32'd0);
            chk("rst.psr", {27'b0, psr}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst.done", {31'b0, done}, 32'd0);

        regs[3] = 16'h000A; regs[2] = 16'h000A;
        run("add1", 16'h0253, 1'b1, 16'h0014, 1'b1, 5'b00000);
        chk("add1.r2", {16'b0, regs[2]}, 32'h14);

        regs[1] = 16'hFFFF; regs[2] = 16'hFFFF;
        run("add2", 16'h0251, 1'b1, 16'hFFFE, 1'b1, 5'b10001);

        regs[1] = 16'h0001; regs[2] = 16'hFFFF;
        run("cmp", 16'h02B1, 1'b0, 16'h0, 1'b1, 5'b00001);
        chk("cmp.r2", {16'b0, regs[2]}, 32'hFFFF);

        regs[1] = 16'h0005; regs[2] = 16'h0005;
        run("cmpeq", 16'h02B1, 1'b0, 16'h0, 1'b1, 5'b00010);

        regs[1] = 16'h0005; regs[2] = 16'h0003;
        run("sub", 16'h0291, 1'b1, 16'hFFFE, 1'b1, 5'b11001);

        regs[1] = 16'h0F0F; regs[2] = 16'h00F0;
        run("and", 16'h0211, 1'b1, 16'h0000, 1'b1, 5'b11010);

        regs[1] = 16'h8000; regs[2] = 16'h1234;
        run("mov", 16'h02D1, 1'b1, 16'h8000, 1'b1, 5'b11001);

        regs[2] = 16'h4321;
        run("ill", 16'h02F1, 1'b0, 16'h0, 1'b0, 5'b11001);
        chk("ill.r2", {16'b0, regs[2]}, 32'h4321);

        regs[2] = 16'h0001; cur_imm = 16'hFFFF;
`ifdef EXEC_IMM_EN
        run("addi", 16'h52FF, 1'b1, 16'h0000, 1'b1, 5'b11010);
`else
        run("addi", 16'h52FF, 1'b0, 16'h0, 1'b0, 5'b11001);
`endif

        regs[1] = 16'h0001; regs[2] = 16'h7FFF;
        run("ovf", 16'h0251, 1'b1, 16'h8000, 1'b1, 5'b01101);

        // Abort in EXEC: nothing may be written and psr must clear.
        regs[3] = 16'h0001; regs[2] = 16'h0001;
        step();
        instr_valid = 1'b1;
        instr       = 16'h0253;
        step();
        instr_valid = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("abort.regwrite", {31'b0, regwrite}, 32'd0);
        chk("abort.psr", {27'b0, psr}, 32'd0);
        chk("abort.ready", {31'b0, instr_ready}, 32'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort.nowrite", {31'b0, regwrite | done}, 32'd0);
            chk("abort.idle", {31'b0, instr_ready}, 32'd1);
        end
        chk("abort.r2", {16'b0, regs[2]}, 32'h1);
        chk("abort.psr_after", {27'b0, psr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
